// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, next-PC select codes and
// instruction field bounds used by the fetch unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  // Handshake: mem_req rises with a stable mem_addr and stays high until the
  // cycle mem_ack is seen (inclusive); mem_rdata is valid only with mem_ack,
  // and mem_ack while mem_req is low is ignored.
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit_pc_mux.sv
// Combinational 4:1 next-PC selector; the hold code returns the current PC.
module pc_mux
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  pcsrc_e          i_sel,
  input  logic [PC_W-1:0] i_alu_result,
  input  logic [PC_W-1:0] i_alu_out,
  input  logic [PC_W-1:0] i_jump,
  input  logic [PC_W-1:0] i_pc,
  output logic [PC_W-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PCSRC_ALU:    o_next_pc = i_alu_result;
      PCSRC_ALUOUT: o_next_pc = i_alu_out;
      PCSRC_JUMP:   o_next_pc = i_jump;
      default:      o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle CPU fetch stage: program counter, ALU output register and an
// IDLE/REQ/DONE fetch FSM that loads the instruction register from memory.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write,
  input  logic               pc_write_cond,
  input  logic [1:0]         pc_source,
  input  logic               ir_write,
  input  logic               zero,
  input  logic [PC_W-1:0]    alu_result,
  fetch_unit_if.master       mem,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [15:0]        imm16,
  output logic               ir_valid,
  output logic               stall,
  output fetch_state_e       o_dbg_state
);

  fetch_state_e       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_alu_out;
  logic [PC_W-1:0]    r_fetch_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               r_mem_req;
  logic               r_stall;
  logic               r_ir_valid;

  logic               w_pc_en;
  logic [PC_W-1:0]    w_jump_target;
  logic [PC_W-1:0]    w_next_pc;

  assign w_pc_en = pc_write | (pc_write_cond & zero);

  // Jumps replace only the low 16 bits; wider PCs keep their upper region.
  generate
    if (PC_W > 16) begin : g_wide_jump
      assign w_jump_target = {r_pc[PC_W-1:16], r_instr[15:0]};
    end else begin : g_narrow_jump
      assign w_jump_target = r_instr[PC_W-1:0];
    end
  endgenerate

  pc_mux #(.PC_W(PC_W)) u_pc_mux (
    .i_sel        (pcsrc_e'(pc_source)),
    .i_alu_result (alu_result),
    .i_alu_out    (r_alu_out),
    .i_jump       (w_jump_target),
    .i_pc         (r_pc),
    .o_next_pc    (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_alu_out <= '0;
    end else begin
      r_alu_out <= alu_result;
      if (w_pc_en) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // The fetch address is latched on issue so PC updates mid-fetch do not
  // disturb the outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= '0;
      r_instr      <= '0;
      r_mem_req    <= 1'b0;
      r_stall      <= 1'b0;
      r_ir_valid   <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ir_write) begin
            r_state      <= ST_REQ;
            r_fetch_addr <= r_pc;
            r_mem_req    <= 1'b1;
            r_stall      <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem.mem_ack) begin
            r_state    <= ST_DONE;
            r_instr    <= mem.mem_rdata;
            r_mem_req  <= 1'b0;
            r_stall    <= 1'b0;
            r_ir_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_stall   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_fetch_addr;
  assign pc           = r_pc;
  assign instr        = r_instr;
  assign op           = r_instr[OP_HI:OP_LO];
  assign imm16        = r_instr[IMM_HI:IMM_LO];
  assign ir_valid     = r_ir_valid;
  assign stall        = r_stall;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning the width of the word-addressed program counter.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning the instruction width.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port pc_write, input, 1, the unconditional PC update from the controller.
REQ-006 SHALL have port pc_write_cond, input, 1, the PC update taken only when zero=1.
REQ-007 SHALL have port pc_source, input, 2, the next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold.
REQ-008 SHALL have port ir_write, input, 1, a request to fetch the instruction at the current PC.
REQ-009 SHALL have port zero, input, 1, the ALU zero flag.
REQ-010 SHALL have port alu_result, input, PC_W, the combinational ALU output.
REQ-011 SHALL have port mem_req, output, 1, the instruction-memory read request.
REQ-012 SHALL have port mem_addr, output, PC_W, the read address.
REQ-013 SHALL have port mem_ack, input, 1, the read-data-valid strobe.
REQ-014 SHALL have port mem_rdata, input, INSTR_W, the read data.
REQ-015 SHALL have port pc, output, PC_W, the current program counter.
REQ-016 SHALL have port instr, output, INSTR_W, the instruction register.
REQ-017 SHALL have port op, output, 6, instr[31:26], which feeds the controller opcode input.
REQ-018 SHALL have port imm16, output, 16, instr[15:0].
REQ-019 SHALL have port ir_valid, output, 1, a one-cycle pulse when instr is newly loaded.
REQ-020 SHALL have port stall, output, 1, high while a fetch is outstanding.

Function
REQ-021 SHALL implement a 3-state FSM with states IDLE, REQ and DONE.
- IDLE -> REQ on ir_write=1.
- REQ -> DONE on mem_ack=1.
- DONE -> IDLE unconditionally.
REQ-022 SHALL capture pc into an internal fetch-address register on the IDLE->REQ transition, and SHALL drive mem_addr from that register.
REQ-023 SHALL hold mem_req=1 throughout REQ, including the cycle in which mem_ack arrives; mem_req SHALL be 0 in IDLE and DONE.
REQ-024 SHALL load instr from mem_rdata on the REQ->DONE edge; ir_valid SHALL be 1 only in DONE.
REQ-025 SHALL drive stall=1 in REQ and 0 in all other states.
REQ-026 SHALL ignore ir_write while in REQ or DONE, with no queuing.
REQ-027 SHALL ignore mem_ack in IDLE and DONE (stray acks).
REQ-028 SHALL give a minimum fetch latency of 2 cycles from ir_write to ir_valid, when mem_ack is returned in the first REQ cycle.
REQ-029 SHALL register alu_out from alu_result every cycle.
REQ-030 SHALL form the jump target as {pc[PC_W-1:16], instr[15:0]} when PC_W>16, and as instr[PC_W-1:0] otherwise.
REQ-031 SHALL compute pc_en = pc_write | (pc_write_cond & zero), and SHALL load pc from the pc_source selection on a clock edge where pc_en=1.
REQ-032 SHALL hold pc when pc_source=11, even if pc_en=1.
REQ-033 SHALL allow pc updates in any FSM state; an outstanding fetch SHALL still use its captured address.
REQ-034 SHALL let pc wrap modulo 2^PC_W, with no overflow flag.
REQ-035 SHALL, when pc_write and pc_write_cond are both 1, perform the update regardless of zero.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, set pc=0, instr=0, alu_out=0, the fetch address=0 and the FSM to IDLE; as a result mem_req=0, stall=0 and ir_valid=0 from the following cycle.
REQ-037 SHALL, on reset during REQ, abandon the fetch, and SHALL not load a mem_ack arriving after reset into instr.
REQ-038 SHALL give reset priority over ir_write, pc_write and mem_ack in the same cycle.

Structure
REQ-039 SHALL take the FSM state encoding, the pc_source codes (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD) and the opcode field bounds from the shared package cpu_pkg.
REQ-040 SHALL contain one sub-module, pc_mux, a combinational 4:1 next-PC selector; all other logic is inline.

Verification
REQ-041 SHALL cover: reset, then ir_write=1, mem_ack in the first REQ cycle with mem_rdata=0x04000005 -> mem_addr=0, ir_valid pulse 2 cycles after ir_write, op=6'b000001, imm16=0x0005.
REQ-042 SHALL cover: mem_ack delayed 3 cycles -> stall=1 for exactly 4 cycles, mem_req held, one ir_valid pulse.
REQ-043 SHALL cover: pc_write_cond=1, pc_source=01, alu_out=0x0040, with zero=0 then zero=1 -> pc unchanged, then pc=0x0040.
REQ-044 SHALL cover: pc=0x0003, pc_write=1, pc_source=00, alu_result=0x0004 during REQ -> mem_addr stays 0x0003 and pc=0x0004 next cycle.
REQ-045 SHALL cover: pc=0xFFFF, pc_write=1, alu_result=0x0000 -> pc wraps to 0x0000.
REQ-046 SHALL cover: reset asserted mid-REQ, then mem_ack=1 with data 0xDEADBEEF -> instr=0, ir_valid never pulses, FSM stays in IDLE.
